mgau_sl_reader: RTL and testbench

MGAU_SL_READER -- requirements
Module: mgau_sl_reader

---
 rtl/mgau_sl_reader_if.sv | 41 ++++
 rtl/mgau_sl_reader.sv | 170 +++++++++++++++++
 tb/tb_mgau_sl_reader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mgau_sl_reader_if.sv
// Bus bundle between the shortlist reader and its environment: frame
// control (go/start/done), the score handshake from the shortlist
// producer, read ports of the shortlist and gauscore RAMs, the output
// beat stream and the error flags.
//   master : the reader (drives start, score_received, RAM addresses,
//            output beat, done and error flags)
//   slave  : the environment (drives go, score, RAM data, out_ready)
interface mgau_sl_reader_if #(
  parameter int data_width = 32,
  parameter int addr_width = 32
);
  logic                  go;
  logic                  start;
  logic [data_width-1:0] score;
  logic                  score_ready;
  logic                  score_received;
  logic [addr_width-1:0] sl_addr;
  logic [data_width-1:0] sl_data_out;
  logic [addr_width-1:0] gs_addr;
  logic [data_width-1:0] gs_data_out;
  logic [data_width-1:0] out_idx;
  logic [data_width-1:0] out_score;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  done;
  logic                  err_sentinel;
  logic                  err_range;

  modport master (
    input  go, score, score_ready, sl_data_out, gs_data_out, out_ready,
    output start, score_received, sl_addr, gs_addr, out_idx, out_score,
           out_valid, out_last, done, err_sentinel, err_range
  );

  modport slave (
    output go, score, score_ready, sl_data_out, gs_data_out, out_ready,
    input  start, score_received, sl_addr, gs_addr, out_idx, out_score,
           out_valid, out_last, done, err_sentinel, err_range
  );
endinterface

// File: rtl/mgau_sl_reader.sv
// Shortlist reader: for each frame, launches the shortlist producer, takes
// the shortlist count, then for every listed gaussian reads its index from
// the shortlist RAM and its score from the gauscore RAM and emits the pair
// as one valid/ready beat. Afterwards it checks that the slot just past the
// list holds the -1 sentinel.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mgau_sl_reader_if.master (control, score handshake, RAM read
//          ports, output beat stream, done and error flags)
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | after reset, waiting for go
// START      | one-cycle start pulse to the shortlist producer
// WAIT_SCORE | waiting for score_ready, latch count
// ACK        | one-cycle score_received, range check, pick next step
// RD_SL      | present shortlist address ptr
// RD_GS      | capture gaussian index, present it as gauscore address
// EMIT       | hold output beat until accepted
// CHK_SENT   | two cycles: present address cnt, then compare data to -1
// DONE       | frame complete, waiting for go
module mgau_sl_reader #(
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int max_sl     = 9
) (
  input logic           clk,
  input logic           rst,
  mgau_sl_reader_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, START, WAIT_SCORE, ACK, RD_SL, RD_GS, EMIT, CHK_SENT, DONE
  } state_t;

  localparam logic [data_width-1:0] one_w    = data_width'(1);
  localparam logic [data_width-1:0] max_sl_w = data_width'(max_sl);

  state_t                state_q, state_d;
  logic [data_width-1:0] cnt_q, cnt_d;
  logic [data_width-1:0] ptr_q, ptr_d;
  logic [data_width-1:0] idx_q, idx_d;
  logic [data_width-1:0] score_q, score_d;
  logic                  emit_first_q, emit_first_d;
  logic                  chk_phase_q, chk_phase_d;
  logic                  err_sent_q, err_sent_d;
  logic                  err_range_q, err_range_d;
  logic                  is_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      score_q      <= '0;
      emit_first_q <= 1'b0;
      chk_phase_q  <= 1'b0;
      err_sent_q   <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      score_q      <= score_d;
      emit_first_q <= emit_first_d;
      chk_phase_q  <= chk_phase_d;
      err_sent_q   <= err_sent_d;
      err_range_q  <= err_range_d;
    end
  end

  assign is_last = (ptr_q == cnt_q - one_w);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    score_d      = score_q;
    emit_first_d = 1'b0;
    chk_phase_d  = 1'b0;
    err_sent_d   = err_sent_q;
    err_range_d  = err_range_q;

    bus.start          = 1'b0;
    bus.score_received = 1'b0;
    bus.sl_addr        = '0;
    bus.gs_addr        = '0;
    bus.out_valid      = 1'b0;
    bus.out_last       = 1'b0;
    bus.done           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.go) state_d = START;
      end
      START: begin
        bus.start = 1'b1;
        state_d   = WAIT_SCORE;
      end
      WAIT_SCORE: begin
        if (bus.score_ready) begin
          cnt_d   = bus.score;
          state_d = ACK;
        end
      end
      ACK: begin
        bus.score_received = 1'b1;
        ptr_d              = '0;
        if (cnt_q >= max_sl_w) begin
          err_range_d = 1'b1;
          state_d     = DONE;
        end else if (cnt_q == '0) begin
          state_d = CHK_SENT;
        end else begin
          state_d = RD_SL;
        end
      end
      RD_SL: begin
        bus.sl_addr = addr_width'(ptr_q);
        state_d     = RD_GS;
      end
      RD_GS: begin
        idx_d        = bus.sl_data_out;
        bus.gs_addr  = addr_width'(bus.sl_data_out);
        emit_first_d = 1'b1;
        state_d      = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = is_last;
        // gauscore data is only present in the first EMIT cycle; keep a copy
        if (emit_first_q) score_d = bus.gs_data_out;
        if (bus.out_ready) begin
          ptr_d   = ptr_q + one_w;
          state_d = is_last ? CHK_SENT : RD_SL;
        end
      end
      CHK_SENT: begin
        if (!chk_phase_q) begin
          bus.sl_addr = addr_width'(cnt_q);
          chk_phase_d = 1'b1;
        end else begin
          if (bus.sl_data_out != '1) err_sent_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.go) begin
          err_sent_d  = 1'b0;
          err_range_d = 1'b0;
          state_d     = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // First EMIT cycle forwards the RAM output directly so the beat carries
  // its score in the same cycle out_valid rises.
  assign bus.out_score    = emit_first_q ? bus.gs_data_out : score_q;
  assign bus.out_idx      = idx_q;
  assign bus.err_sentinel = err_sent_q;
  assign bus.err_range    = err_range_q;

endmodule

// File: tb/tb_mgau_sl_reader.sv
// Testbench for mgau_sl_reader: models both RAMs with registered-address
// reads, drives directed and random frames, and compares every accepted
// beat, the done/error flags and the handshake pulse counts against the
// expected shortlist contents.
module tb_mgau_sl_reader;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   start_cnt, rcv_cnt, addr_nz;

  logic [31:0] sl_mem [16];
  logic [31:0] gs_mem [16];

  mgau_sl_reader_if #(.data_width(32), .addr_width(32)) bus ();

  mgau_sl_reader #(.data_width(32), .addr_width(32), .max_sl(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.sl_data_out <= sl_mem[bus.sl_addr[3:0]];
    bus.gs_data_out <= gs_mem[bus.gs_addr[3:0]];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.start)                      start_cnt++;
      if (bus.score_received)             rcv_cnt++;
      if (bus.sl_addr != 0 || bus.gs_addr != 0) addr_nz++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"},   64'(bus.start), 0);
    check({tag, "_rcv"},     64'(bus.score_received), 0);
    check({tag, "_valid"},   64'(bus.out_valid), 0);
    check({tag, "_last"},    64'(bus.out_last), 0);
    check({tag, "_done"},    64'(bus.done), 0);
    check({tag, "_esent"},   64'(bus.err_sentinel), 0);
    check({tag, "_erange"},  64'(bus.err_range), 0);
    check({tag, "_idx"},     64'(bus.out_idx), 0);
    check({tag, "_score"},   64'(bus.out_score), 0);
    check({tag, "_sladdr"},  64'(bus.sl_addr), 0);
    check({tag, "_gsaddr"},  64'(bus.gs_addr), 0);
  endtask

  // Pulse go, wait for start, deliver the count and wait for its acknowledge.
  task automatic open_frame(input string tag, input logic [31:0] cnt);
    int guard;
    start_cnt = 0; rcv_cnt = 0; addr_nz = 0;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    guard = 0;
    while (!bus.start && guard < 10) begin @(negedge clk); guard++; end
    check({tag, "_start_seen"}, 64'(bus.start), 1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.score = cnt;
    bus.score_ready = 1'b1;
    guard = 0;
    while (!bus.score_received && guard < 10) begin @(negedge clk); guard++; end
    check({tag, "_rcv_seen"}, 64'(bus.score_received), 1);
  endtask

  // mode 0: out_ready always 1; mode 1: random out_ready and stray go;
  // mode 2: out_ready held low for 4 cycles while beat 2 is offered.
  task automatic run_frame(input string tag, input logic [31:0] cnt, input int mode);
    int   beats, stalls, stall_left, guard, exp_beats;
    bit   prev_stall, exp_range, exp_sent;
    logic ready;
    logic [31:0] p_idx, p_score, e_idx;
    logic p_last;
    exp_range = (cnt >= 32'd9);
    exp_sent  = !exp_range && (sl_mem[cnt[3:0]] != 32'hFFFF_FFFF);
    exp_beats = exp_range ? 0 : int'(cnt);
    bus.out_ready = $urandom_range(0, 1) == 1;
    open_frame(tag, cnt);
    // holding score_ready a little longer must not trigger a second latch
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.score_ready = 1'b0;
    bus.score = $urandom;
    beats = 0; stalls = 0; stall_left = 4; prev_stall = 0; guard = 0;
    p_idx = '0; p_score = '0; p_last = 1'b0;
    while (!bus.done && guard < 300) begin
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 64'(bus.out_valid), 1);
        check({tag, "_hold_idx"},   64'(bus.out_idx), 64'(p_idx));
        check({tag, "_hold_score"}, 64'(bus.out_score), 64'(p_score));
        check({tag, "_hold_last"},  64'(bus.out_last), 64'(p_last));
      end
      if (bus.out_valid) begin
        case (mode)
          0: ready = 1'b1;
          1: ready = $urandom_range(0, 1) == 1;
          default: begin
            if (beats == 1 && stall_left > 0) begin ready = 1'b0; stall_left--; end
            else ready = 1'b1;
          end
        endcase
      end else begin
        ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
      bus.out_ready = ready;
      if (mode == 1) bus.go = $urandom_range(0, 1) == 1;
      prev_stall = bus.out_valid && !ready;
      if (prev_stall) begin
        stalls++;
        p_idx = bus.out_idx; p_score = bus.out_score; p_last = bus.out_last;
      end
      if (bus.out_valid && ready) begin
        if (beats < exp_beats) begin
          e_idx = sl_mem[beats];
          check({tag, "_beat_idx"},   64'(bus.out_idx), 64'(e_idx));
          check({tag, "_beat_score"}, 64'(bus.out_score), 64'(gs_mem[e_idx[3:0]]));
          check({tag, "_beat_last"},  64'(bus.out_last), 64'(beats == exp_beats - 1));
        end
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    bus.go = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_done"},      64'(bus.done), 1);
    check({tag, "_beats"},     64'(beats), 64'(exp_beats));
    check({tag, "_err_range"}, 64'(bus.err_range), 64'(exp_range));
    check({tag, "_err_sent"},  64'(bus.err_sentinel), 64'(exp_sent));
    check({tag, "_starts"},    64'(start_cnt), 1);
    check({tag, "_acks"},      64'(rcv_cnt), 1);
    check({tag, "_valid_end"}, 64'(bus.out_valid), 0);
    if (mode == 2)  check({tag, "_stalls"},  64'(stalls), 4);
    if (exp_range)  check({tag, "_addr_zero"}, 64'(addr_nz), 0);
  endtask

  task automatic load_normal();
    for (int i = 0; i < 16; i++) begin sl_mem[i] = $urandom; gs_mem[i] = $urandom; end
    sl_mem[0] = 32'd2; sl_mem[1] = 32'd5; sl_mem[2] = 32'd7; sl_mem[3] = 32'hFFFF_FFFF;
    gs_mem[2] = 32'hFFFF_FF9C;  // -100
    gs_mem[5] = 32'hFFFF_FF38;  // -200
    gs_mem[7] = 32'hFFFF_FED4;  // -300
  endtask

  initial begin
    int guard;
    logic [31:0] rc;
    rst = 1'b1;
    bus.go = 1'b0; bus.score = '0; bus.score_ready = 1'b0; bus.out_ready = 1'b0;
    load_normal();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    run_frame("normal", 32'd3, 0);
    run_frame("backpressure", 32'd3, 2);

    sl_mem[0] = 32'hFFFF_FFFF;
    run_frame("empty", 32'd0, 1);

    sl_mem[0] = 32'd1; sl_mem[1] = 32'd3; sl_mem[2] = 32'd4;
    run_frame("sentinel", 32'd2, 1);

    run_frame("range", 32'd9, 1);

    // reset while a beat is offered and out_ready is high
    load_normal();
    open_frame("rst_mid", 32'd3);
    bus.score_ready = 1'b0;
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin @(negedge clk); guard++; end
    check("rst_mid_valid_seen", 64'(bus.out_valid), 1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    run_frame("after_rst", 32'd3, 0);

    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 5))
        0:       rc = 32'd9 + $urandom_range(0, 30);
        1:       rc = 32'hFFFF_FFFF;
        default: rc = $urandom_range(0, 8);
      endcase
      for (int i = 0; i < 16; i++) begin
        sl_mem[i] = $urandom_range(0, 15);
        gs_mem[i] = $urandom;
      end
      if (rc < 32'd9)
        sl_mem[rc[3:0]] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : 32'hFFFF_FFFF;
      run_frame("random", rc, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
